// File: rtl/mono_rx_fifo_arbiter_if.sv
// ============================================================================
// Module   : mono_rx_fifo_arbiter_if
// Brief    : Source-side and sink-side FIFO signals of the receiver arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mono_rx_fifo_arbiter_if #(
  parameter int N_IN = 4
);
  logic                 ENABLE;
  logic [N_IN-1:0]      MASK;
  logic [N_IN-1:0]      IN_FIFO_EMPTY;
  logic [32*N_IN-1:0]   IN_FIFO_DATA;
  logic [N_IN-1:0]      IN_FIFO_READ;
  logic                 OUT_FIFO_READ;
  logic                 OUT_FIFO_EMPTY;
  logic [31:0]          OUT_FIFO_DATA;
  logic [N_IN-1:0]      GRANT;
  logic                 BUSY;

  // The arbiter is the master side.
  modport master (
    input  ENABLE, MASK, IN_FIFO_EMPTY, IN_FIFO_DATA, OUT_FIFO_READ,
    output IN_FIFO_READ, OUT_FIFO_EMPTY, OUT_FIFO_DATA, GRANT, BUSY
  );

  modport slave (
    output ENABLE, MASK, IN_FIFO_EMPTY, IN_FIFO_DATA, OUT_FIFO_READ,
    input  IN_FIFO_READ, OUT_FIFO_EMPTY, OUT_FIFO_DATA, GRANT, BUSY
  );
endinterface

`default_nettype wire

// File: rtl/mono_rx_fifo_arbiter.sv
// ============================================================================
// Module   : mono_rx_fifo_arbiter
// Brief    : Round-robin burst arbiter merging N_IN FWFT receiver FIFOs into
//            one registered FIFO-style stream. Optional MONO_ARB_SRCTAG_EN
//            replaces output bits [31:28] with the source index.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mono_rx_fifo_arbiter #(
  parameter int N_IN  = 4,
  parameter int BURST = 16
) (
  input  wire logic               BUS_CLK,
  input  wire logic               BUS_RST,
  mono_rx_fifo_arbiter_if.master  bus
);

  localparam int              IDXW     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [7:0]      LAST_CNT = 8'(BURST - 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_IN - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   sel_q, sel_d;
  logic [IDXW-1:0]   last_q, last_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              out_full_q, out_full_d;
  logic [31:0]       out_data_q, out_data_d;

  logic [31:0]       w_src_words [N_IN];
  logic              w_hit;
  logic [IDXW-1:0]   w_hit_idx;
  logic [IDXW-1:0]   w_cand;
  logic              w_src_ok;
  logic              w_pop;
  logic [31:0]       w_load_word;
  logic [N_IN-1:0]   w_grant;
  logic [N_IN-1:0]   w_read;

  for (genvar g = 0; g < N_IN; g++) begin : g_src
    assign w_src_words[g] = bus.IN_FIFO_DATA[32*g +: 32];
  end

  // Rotating search starting one past the most recently granted source.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_cand    = '0;
    for (int k = 1; k <= N_IN; k++) begin
      w_cand = IDXW'((int'(last_q) + k) % N_IN);
      if (!w_hit && bus.MASK[w_cand] && !bus.IN_FIFO_EMPTY[w_cand]) begin
        w_hit     = 1'b1;
        w_hit_idx = w_cand;
      end
    end
  end

`ifdef MONO_ARB_SRCTAG_EN
  logic [3:0] w_sel_tag;
  assign w_sel_tag   = 4'(sel_q);
  assign w_load_word = {w_sel_tag, w_src_words[sel_q][27:0]};
`else
  assign w_load_word = w_src_words[sel_q];
`endif

  assign w_src_ok = bus.ENABLE && bus.MASK[sel_q] && !bus.IN_FIFO_EMPTY[sel_q];

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    out_full_d = out_full_q;
    out_data_d = out_data_q;
    w_pop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_hit && bus.ENABLE) begin
          state_d = ST_GRANT;
          sel_d   = w_hit_idx;
          last_d  = w_hit_idx;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        w_pop = w_src_ok && (!out_full_q || bus.OUT_FIFO_READ);
        if (w_pop) begin
          cnt_d = cnt_q + 8'd1;
        end
        if (!w_src_ok || (w_pop && (cnt_q == LAST_CNT))) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A load wins over a read so simultaneous read+pop keeps the stage full.
    if (w_pop) begin
      out_full_d = 1'b1;
      out_data_d = w_load_word;
    end else if (bus.OUT_FIFO_READ) begin
      out_full_d = 1'b0;
    end
  end

  always_comb begin
    w_grant = '0;
    w_read  = '0;
    if (state_q == ST_GRANT) begin
      w_grant[sel_q] = 1'b1;
    end
    if (w_pop) begin
      w_read[sel_q] = 1'b1;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      last_q     <= LAST_IDX;
      cnt_q      <= '0;
      out_full_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      out_full_q <= out_full_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.IN_FIFO_READ   = w_read;
  assign bus.GRANT          = w_grant;
  assign bus.OUT_FIFO_EMPTY = !out_full_q;
  assign bus.OUT_FIFO_DATA  = out_data_q;
  assign bus.BUSY           = (state_q == ST_GRANT) || out_full_q;

endmodule

`default_nettype wire

// File: doc/mono_rx_fifo_arbiter.md
# mono_rx_fifo_arbiter

- Round-robin read arbiter that merges the 32-bit FIFO outputs of up to N_IN `mono_data_rx` instances into one FIFO-style stream.
- Downstream consumer is the readout SRAM FIFO.
- Reads each source through its FWFT pop interface.
- Grants bounded bursts for fairness and registers the selected word into a single-entry output stage.

## Interface
Parameters:
- N_IN, 4, number of source receivers (2..16)
- BURST, 16, max words popped per grant before rotating (1..255)

Ports:
- BUS_CLK  in  1  sole clock
- BUS_RST  in  1  synchronous, active-high reset
- ENABLE  in  1  global arbitration enable
- MASK  in  N_IN  per-source enable, 1 = eligible
- IN_FIFO_EMPTY  in  N_IN  source empty flags
- IN_FIFO_DATA  in  32*N_IN  source words; source i occupies bits [32i+31:32i]; valid while its EMPTY=0
- IN_FIFO_READ  out  N_IN  source pop strobes, at most one high per cycle
- OUT_FIFO_READ  in  1  downstream pop
- OUT_FIFO_EMPTY  out  1  1 = output stage holds no word
- OUT_FIFO_DATA  out  32  output stage word
- GRANT  out  N_IN  one-hot current grant, 0 in IDLE
- BUSY  out  1  state is GRANT or output stage full

## Operation
State machine:
- IDLE: search from (last+1) mod N_IN upward, with wrap, for the first index with MASK=1 and EMPTY=0.
  - A hit with ENABLE=1 latches `sel` and `last` to that index, clears the burst counter and enters GRANT.
  - No hit: remain in IDLE.
- GRANT: pop = GRANT[sel] & ~IN_FIFO_EMPTY[sel] & (OUT_FIFO_EMPTY | OUT_FIFO_READ).
  - IN_FIFO_READ[sel] = pop, combinational. All other strobes are 0.
  - On pop, the output stage loads IN_FIFO_DATA[sel] and the burst counter increments (8-bit).
- Exit GRANT to IDLE at the clock edge where any of these holds:
  - pop with counter == BURST-1
  - IN_FIFO_EMPTY[sel]=1
  - MASK[sel]=0
  - ENABLE=0

Output stage:
- Full after a load. Emptied by OUT_FIFO_READ when not refilled in the same cycle.
- A simultaneous read and pop keeps the stage full with the new word, so back-to-back throughput is 1 word/cycle.
- OUT_FIFO_READ while empty is ignored.

Fairness:
- `last` only changes on grant, so after a burst the next search starts past the previous source.
- A lone active source is re-granted after one IDLE bubble.

## Timing
- Reset values: IN_FIFO_READ=0, OUT_FIFO_EMPTY=1, OUT_FIFO_DATA=0, GRANT=0, BUSY=0, state IDLE, last=N_IN-1 (so source 0 has first priority).
- Latency: source goes non-empty at edge k → GRANT at k+1 → IN_FIFO_READ high during cycle k+1 → OUT_FIFO_EMPTY=0 after edge k+2.
- Sustained rate per burst: BURST words in BURST cycles, then 1 IDLE cycle.
- ENABLE or MASK dropping mid-burst:
  - No pop in that cycle.
  - Return to IDLE.
  - A word already held in the output stage remains readable.
- BUS_RST mid-burst: any held output word is discarded. Source FIFOs are untouched.
- Downstream stall (OUT_FIFO_READ=0 with stage full): no pop, counter frozen, grant held.

## Configuration
- MONO_ARB_SRCTAG_EN defined: on load, bits [31:28] of the output word are replaced by sel[3:0]. This lets software identify the source receiver.
- Not defined: the word passes unmodified.
- Tagging never affects timing or arbitration.

## Test plan
- Reset then idle: all inputs empty, ENABLE=1 → GRANT=0, OUT_FIFO_EMPTY=1 and IN_FIFO_READ=0 for 100 cycles.
- Single source: source 2 holds 5 words 0x100..0x104, OUT_FIFO_READ=1 continuously.
  - Expect 0x100..0x104 in order, first word 2 cycles after ENABLE.
  - Expect exactly 5 IN_FIFO_READ[2] pulses, then IDLE.
- Round-robin with BURST=4: sources 0 and 1 each hold 10 words → output order 0:4, 1:4, 0:4, 1:4, 0:2, 1:2, with one bubble cycle between bursts.
- Backpressure: OUT_FIFO_READ toggles 1/0 during a burst → no word lost or duplicated, and no pop while the stage is full without a read.
- Mid-burst abort: clear MASK[sel] after 3 pops of 8 words → exactly 3 words out, then grant moves to the next eligible source. Reasserting MASK later delivers the remaining 5.
- Tag macro: with MONO_ARB_SRCTAG_EN, source 3 word 0xFFFFFFFF → output 0x3FFFFFFF. Without the macro → 0xFFFFFFFF.
